// File: rtl/debug_snapshot_tx_pkg.sv
// Shared definitions for the debug snapshot transmitter: FSM states,
// frame constants and word positions inside the snapshot.
package debug_snapshot_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_WORDS  = 3'd2,
    ST_FLAGS  = 3'd3,
    ST_CSUM   = 3'd4
  } state_e;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;
  localparam int         FRAME_LEN   = 35;
  localparam int         SNAP_W      = 32;

  // Word positions inside the snapshot, in transmit order
  localparam logic [2:0] W_CYCLE = 3'd0;
  localparam logic [2:0] W_PC    = 3'd1;
  localparam logic [2:0] W_IFID  = 3'd2;
  localparam logic [2:0] W_RD1   = 3'd3;
  localparam logic [2:0] W_RD2   = 3'd4;
  localparam logic [2:0] W_EXMEM = 3'd5;
  localparam logic [2:0] W_MEMWB = 3'd6;
  localparam logic [2:0] W_WB    = 3'd7;

  // Byte idx of a snapshot word, idx 3 is the MSB
  function automatic logic [7:0] word_byte(input logic [SNAP_W-1:0] w,
                                           input logic [1:0] idx);
    logic [SNAP_W-1:0] sh;
    sh = w >> {idx, 3'b000};
    return sh[7:0];
  endfunction

endpackage

// File: rtl/debug_snapshot_tx_reg.sv
// Snapshot capture bank plus the free-running cycle counter. A single
// load strobe freezes every pipeline observation and the counter value.
module debug_snapshot_reg
  import debug_snapshot_tx_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 8
) (
  input  logic                              clk_in,
  input  logic                              rst_n,
  input  logic                              load,
  input  logic [DATA_W-1:0]                 snap_pc,
  input  logic [DATA_W-1:0]                 snap_ifid_instr,
  input  logic [DATA_W-1:0]                 snap_idex_rd1,
  input  logic [DATA_W-1:0]                 snap_idex_rd2,
  input  logic [DATA_W-1:0]                 snap_exmem_alu,
  input  logic [DATA_W-1:0]                 snap_memwb_alu,
  input  logic [DATA_W-1:0]                 snap_wb_data,
  input  logic                              snap_stall,
  input  logic                              snap_flush,
  output logic [NUM_WORDS-1:0][DATA_W-1:0]  words,
  output logic [7:0]                        flags
);

  logic [DATA_W-1:0]                cnt_d, cnt_q;
  logic [NUM_WORDS-1:0][DATA_W-1:0] words_d, words_q;
  logic [7:0]                       flags_d, flags_q;

  // Next counter value and snapshot contents on a load
  always_comb begin
    cnt_d   = cnt_q + DATA_W'(1);
    words_d = words_q;
    flags_d = flags_q;
    if (load) begin
      words_d[W_CYCLE] = cnt_q;
      words_d[W_PC]    = snap_pc;
      words_d[W_IFID]  = snap_ifid_instr;
      words_d[W_RD1]   = snap_idex_rd1;
      words_d[W_RD2]   = snap_idex_rd2;
      words_d[W_EXMEM] = snap_exmem_alu;
      words_d[W_MEMWB] = snap_memwb_alu;
      words_d[W_WB]    = snap_wb_data;
      flags_d          = {6'b0, snap_flush, snap_stall};
    end
  end

  // Cycle counter clears on reset and wraps naturally
  always_ff @(posedge clk_in) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Snapshot data is only meaningful after a load, so it carries no reset
  always_ff @(posedge clk_in) begin
    words_q <= words_d;
    flags_q <= flags_d;
  end

  assign words = words_q;
  assign flags = flags_q;

endmodule

// File: rtl/debug_snapshot_tx.sv
// Debug snapshot transmitter: freezes one cycle of pipeline state on
// request and streams it as a checksummed 35-byte frame over valid/ready.
module debug_snapshot_tx
  import debug_snapshot_tx_pkg::*;
#(
  parameter int         DATA_W    = 32,
  parameter logic [7:0] HEADER    = HEADER_BYTE,
  parameter int         NUM_WORDS = 8
) (
  input  logic              clk_in,
  input  logic              Reset,
  input  logic              Dump_Start,
  input  logic [DATA_W-1:0] Snap_PC,
  input  logic [DATA_W-1:0] Snap_IFID_Instr,
  input  logic [DATA_W-1:0] Snap_IDEX_RD1,
  input  logic [DATA_W-1:0] Snap_IDEX_RD2,
  input  logic [DATA_W-1:0] Snap_EXMEM_ALU,
  input  logic [DATA_W-1:0] Snap_MEMWB_ALU,
  input  logic [DATA_W-1:0] Snap_WB_Data,
  input  logic              Snap_Stall,
  input  logic              Snap_Flush,
  output logic [7:0]        Tx_Data,
  output logic              Tx_Valid,
  input  logic              Tx_Ready,
  output logic              Busy,
  output logic              Done
);

  state_e     state_d, state_q;
  logic [2:0] word_idx_d, word_idx_q;
  logic [1:0] byte_idx_d, byte_idx_q;
  logic [7:0] tx_data_d, tx_data_q;
  logic       tx_valid_d, tx_valid_q;
  logic       busy_d, busy_q;
  logic       done_d, done_q;
  logic [7:0] csum_d, csum_q;

  logic                             load;
  logic                             xfer;
  logic [2:0]                       next_word;
  logic [1:0]                       next_byte;
  logic [NUM_WORDS-1:0][DATA_W-1:0] snap_words;
  logic [7:0]                       snap_flags;

  assign load = (state_q == ST_IDLE) && Dump_Start;
  assign xfer = tx_valid_q && Tx_Ready;

  debug_snapshot_reg #(
    .DATA_W    (DATA_W),
    .NUM_WORDS (NUM_WORDS)
  ) u_snap (
    .clk_in          (clk_in),
    .rst_n           (Reset),
    .load            (load),
    .snap_pc         (Snap_PC),
    .snap_ifid_instr (Snap_IFID_Instr),
    .snap_idex_rd1   (Snap_IDEX_RD1),
    .snap_idex_rd2   (Snap_IDEX_RD2),
    .snap_exmem_alu  (Snap_EXMEM_ALU),
    .snap_memwb_alu  (Snap_MEMWB_ALU),
    .snap_wb_data    (Snap_WB_Data),
    .snap_stall      (Snap_Stall),
    .snap_flush      (Snap_Flush),
    .words           (snap_words),
    .flags           (snap_flags)
  );

  // Frame sequencing: the next byte is chosen on each accepted transfer
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    csum_d     = csum_q;
    next_word  = word_idx_q + 3'd1;
    next_byte  = byte_idx_q - 2'd1;

    if (xfer) csum_d = csum_q ^ tx_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (Dump_Start) begin
          state_d    = ST_HEADER;
          tx_data_d  = HEADER;
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
          csum_d     = 8'h00;
          word_idx_d = W_CYCLE;
          byte_idx_d = 2'd3;
        end
      end
      ST_HEADER: begin
        if (xfer) begin
          state_d   = ST_WORDS;
          tx_data_d = word_byte(snap_words[W_CYCLE], 2'd3);
        end
      end
      ST_WORDS: begin
        if (xfer) begin
          if (byte_idx_q == 2'd0) begin
            if (word_idx_q == W_WB) begin
              state_d   = ST_FLAGS;
              tx_data_d = snap_flags;
            end else begin
              word_idx_d = next_word;
              byte_idx_d = 2'd3;
              tx_data_d  = word_byte(snap_words[next_word], 2'd3);
            end
          end else begin
            byte_idx_d = next_byte;
            tx_data_d  = word_byte(snap_words[word_idx_q], next_byte);
          end
        end
      end
      ST_FLAGS: begin
        if (xfer) begin
          state_d   = ST_CSUM;
          tx_data_d = csum_q ^ tx_data_q;
        end
      end
      ST_CSUM: begin
        if (xfer) begin
          state_d    = ST_IDLE;
          tx_data_d  = 8'h00;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // FSM and registered outputs; reset aborts any frame in flight
  always_ff @(posedge clk_in) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      word_idx_q <= 3'd0;
      byte_idx_q <= 2'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      csum_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      csum_q     <= csum_d;
    end
  end

  assign Tx_Data  = tx_data_q;
  assign Tx_Valid = tx_valid_q;
  assign Busy     = busy_q;
  assign Done     = done_q;

endmodule

// File: doc/debug_snapshot_tx.md
Name: debug_snapshot_tx

Overview:
Debug-side transmitter for the MIPS pipeline. On request it freezes one cycle's view of the pipeline latches and streams it out as a fixed, checksummed byte frame. The frame carries the PC, IF/ID, ID/EX, EX/MEM, MEM/WB and WB values plus the hazard stall/flush flags. It sits beside the top-level MIPS datapath and feeds a byte-wide UART TX (valid/ready). It is the hardware producer of the same pipeline observation the simulation bench performs by probing.

Parameters:
DATA_W, 32, width of each snapshot word
HEADER, 8'hA5, frame start byte
NUM_WORDS, 8, snapshot words per frame (fixed frame layout below; not intended to be changed)

Ports:
clk_in  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-low reset
Dump_Start  in  1  request pulse; honoured only in IDLE
Snap_PC  in  32  IF program counter
Snap_IFID_Instr  in  32  IF/ID instruction
Snap_IDEX_RD1  in  32  ID/EX read data 1
Snap_IDEX_RD2  in  32  ID/EX read data 2
Snap_EXMEM_ALU  in  32  EX/MEM ALU result
Snap_MEMWB_ALU  in  32  MEM/WB ALU result
Snap_WB_Data  in  32  WB mem-to-reg result
Snap_Stall  in  1  hazard unit stall
Snap_Flush  in  1  IF/ID flush
Tx_Data  out  8  frame byte
Tx_Valid  out  1  Tx_Data valid
Tx_Ready  in  1  sink accepts byte
Busy  out  1  frame in progress
Done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (Reset==0 at clk edge):
  - Tx_Data=0, Tx_Valid=0, Busy=0, Done=0.
  - State returns to IDLE and the cycle counter clears to 0.
  - Reset mid-frame aborts the frame: Tx_Valid is 0 from the next cycle, and no partial resume occurs.
- Cycle counter: internal 32-bit, increments every cycle out of reset, wraps from 0xFFFFFFFF to 0.
- Frame (35 bytes, words sent MSB first):
  - HEADER
  - W0 = cycle count
  - W1 = PC
  - W2 = IFID_Instr
  - W3 = IDEX_RD1
  - W4 = IDEX_RD2
  - W5 = EXMEM_ALU
  - W6 = MEMWB_ALU
  - W7 = WB_Data
  - FLAGS = {6'b0, Flush, Stall}
  - CSUM = XOR of all 34 preceding bytes.
- Capture: in IDLE with Dump_Start=1 at edge N:
  - All Snap_* inputs and the counter value at edge N are registered into the snapshot.
  - Later input changes do not affect the frame.
- Latency: at edge N Busy=1, Tx_Valid=1, Tx_Data=HEADER.
- FSM: IDLE -> HEADER -> WORDS -> FLAGS -> CSUM -> IDLE.
  - WORDS uses a 3-bit word index and a 2-bit byte index; byte index 3->0 wraps and increments the word index.
  - Leaves WORDS after word 7 byte 0.
- Handshake:
  - A byte transfers on an edge with Tx_Valid && Tx_Ready.
  - While Tx_Valid && !Tx_Ready, Tx_Data holds stable.
  - Tx_Valid never drops mid-frame except on reset.
  - Next byte is presented the edge after transfer (back-to-back at 1 byte/cycle when Tx_Ready is held high).
- Checksum: running XOR, updated on each transfer, sent in CSUM.
- End of frame: on CSUM transfer, at the same edge:
  - Tx_Valid=0, Busy=0, Done=1 for exactly one cycle; state returns to IDLE.
  - Dump_Start asserted that same edge is ignored.
  - Dump_Start on the following edge starts a new frame.
- Dump_Start while Busy: ignored, no queueing.

Decomposition:
- Shared package/header holds:
  - FSM state encodings (IDLE, HEADER, WORDS, FLAGS, CSUM).
  - HEADER constant.
  - Frame length 35.
  - Word-index constants W_CYCLE..W_WB.
- One natural sub-module: debug_snapshot_reg, the capture register bank plus free-running cycle counter with a load strobe. FSM, mux and checksum stay in the top.

Test Plan:
- Reset held 3 cycles with Tx_Ready=1 -> Tx_Valid=0, Busy=0, Done=0 throughout; counter=0 after release.
- All Snap_*=0, Dump_Start when counter=5, Tx_Ready=1 -> bytes in 35 consecutive cycles: A5, 00 00 00 05, 28x00, FLAGS=00, CSUM=A0; Done pulses once.
- Snap_PC=0x00400010, Snap_Stall=1, Snap_Flush=1, others 0 -> W1 bytes 00 40 00 10; FLAGS=03; CSUM = A5^count bytes^40^10^03.
- Tx_Ready toggled 1 cycle on / 2 cycles off -> no byte lost or duplicated; Tx_Data stable while stalled; frame identical to the back-to-back case.
- Snap_* inputs changed every cycle during a frame, plus Dump_Start pulses mid-frame -> frame reflects the start-edge values only; exactly one frame and one Done.
- Reset asserted after byte 10 -> Tx_Valid=0 next cycle, Busy=0; a subsequent Dump_Start yields a full fresh 35-byte frame beginning A5.
